// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nibble_serial_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : nibble_serial_sub_pkg

// File: rtl/nibble_serial_sub_sub4_bla.sv
// 4-bit borrow-lookahead subtractor: d = a - b - bin, every borrow as a flat sum of products.
module sub4_bla
    import nibble_serial_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);

    logic [NIBBLE_W-1:0] g_s;
    logic [NIBBLE_W-1:0] p_s;
    logic [NIBBLE_W:0]   br_s;

    // Generate / propagate terms, flattened borrows and difference bits
    always_comb begin
        g_s     = ~a & b;
        p_s     = ~(a ^ b);
        br_s[0] = bin;
        br_s[1] = g_s[0] | (p_s[0] & bin);
        br_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
        br_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & bin);
        br_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & bin);
        d       = a ^ b ^ br_s[NIBBLE_W-1:0];
        bout    = br_s[4];
    end

endmodule : sub4_bla

// File: rtl/nibble_serial_sub.sv
// Nibble-serial unsigned subtractor, one 4-bit step per cycle through a shared sub4_bla.
// Optional signed-overflow output ovf is enabled by NIBBLE_SERIAL_SUB_OVF_EN.
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0] nib_a_s;
    logic [NIBBLE_W-1:0] nib_b_s;
    logic [NIBBLE_W-1:0] nib_d_s;
    logic                nib_bout_s;
    logic                last_s;

    assign nib_a_s = a_q[NIBBLE_W*k_q +: NIBBLE_W];
    assign nib_b_s = b_q[NIBBLE_W*k_q +: NIBBLE_W];
    assign last_s  = (k_q == KW'(N - 1));

    sub4_bla u_sub4_bla (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .bin  (borrow_q),
        .d    (nib_d_s),
        .bout (nib_bout_s)
    );

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = RUN;
                else          state_d = IDLE;
            end
            RUN: begin
                if (last_s) state_d = DONE;
                else        state_d = RUN;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
                else           state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, one nibble per RUN cycle, hold otherwise
    always_comb begin
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    k_d      = '0;
                    diff_d   = '0;
                    bout_d   = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end else begin
                    k_d = k_q;
                end
            end
            RUN: begin
                diff_d[NIBBLE_W*k_q +: NIBBLE_W] = nib_d_s;
                borrow_d = nib_bout_s;
                k_d      = k_q + KW'(1);
                if (last_s) begin
                    bout_d = nib_bout_s;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
                    // On the last step nib_d_s[3] is the result MSB
                    ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (nib_d_s[NIBBLE_W-1] ^ a_q[WIDTH-1]);
`endif
                end else begin
                    bout_d = bout_q;
                end
            end
            DONE: begin
                k_d = k_q;
            end
            default: begin
                k_d = '0;
            end
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign diff = diff_q;
    assign bout = bout_q;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : nibble_serial_sub

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub (WIDTH=8): directed table, corner sequences, random vs model.
module tb_nibble_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        int         hold;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t tbl [10];

    nibble_serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                         output logic [7:0] md, output logic mbo, output logic mov);
        int r;
        r   = int'(ma) - int'(mb) - int'(mbin);
        mbo = (r < 0);
        md  = 8'(r & 255);
        mov = (ma[7] != mb[7]) && (md[7] != ma[7]);
    endtask

    task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_b, input logic tbin,
                           input int hold, input logic [7:0] ed, input logic eb,
                           input logic eo, input string tag);
        int         lat;
        logic [7:0] held_d;
        logic       held_b;
        lat = 0;
        while (!in_ready && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_b; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'($urandom); out_ready = 1'($urandom);
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({tag, " busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom);
        end
        out_ready = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd2);
        chk({tag, " diff"}, 32'(diff), 32'(ed));
        chk({tag, " bout"}, 32'(bout), 32'(eb));
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo !== eo) $display("unreachable");
`endif
        held_d = diff;
        held_b = bout;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
            chk({tag, " hold diff"}, 32'(diff), 32'(ed));
            chk({tag, " hold bout"}, 32'(bout), 32'(held_b));
            chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold ready"}, 32'(in_ready), 32'd0);
            if (held_d !== ed) $display("note: held diff drifted");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " post valid"}, 32'(out_valid), 32'd0);
        chk({tag, " post ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] md;
        logic       mbo;
        logic       mov;
        logic [7:0] ra, rb;
        logic       rbin;

        tbl[0] = '{8'h53, 8'h21, 1'b0, 0, 8'h32, 1'b0, 1'b0};
        tbl[1] = '{8'h10, 8'h01, 1'b0, 0, 8'h0F, 1'b0, 1'b0};
        tbl[2] = '{8'h80, 8'h80, 1'b1, 0, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 5, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 8'h00, 1'b0, 0, 8'hFF, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 8'hFF, 1'b1, 1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b0, 1'b1};
        tbl[8] = '{8'h7F, 8'h01, 1'b0, 0, 8'h7E, 1'b0, 1'b0};
        tbl[9] = '{8'h7F, 8'hFF, 1'b0, 2, 8'h80, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
        chk("reset ovf", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].hold,
                    tbl[i].d, tbl[i].bo, tbl[i].ov, $sformatf("vec%0d", i));
        end

        // Reset after the first RUN edge discards the transaction
        @(posedge clk); #1;
        a = 8'h53; b = 8'h21; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst diff", 32'(diff), 32'd0);
        chk("midrst bout", 32'(bout), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst no output", 32'(out_valid), 32'd0);
        end
        run_txn(8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rbin, md, mbo, mov);
            run_txn(ra, rb, rbin, int'($urandom_range(0, 3)), md, mbo, mov,
                    $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_sub
